// File: rtl/strided_slice_unit.sv
`default_nettype none
// ============================================================================
// Module   : strided_slice_unit
// Purpose  : Captures one IN_LEN-element vector together with a slice
//            descriptor (start, inclusive end, stride) and streams the
//            selected elements out as OUT_LANES-wide beats carrying a
//            lane-valid mask and a last flag.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_data/in_valid/in_ready, start_idx/end_idx/stride
//                                - input vector + descriptor handshake
//            out_data/out_mask/out_valid/out_ready/out_last
//                                - output beat handshake
//            cfg_err             - descriptor error for current transaction
//            busy                - transaction in flight
// Revision : 1.0 - initial release
// ============================================================================
module strided_slice_unit #(
    parameter int                DATA_W    = 16,
    parameter int                IN_LEN    = 64,
    parameter int                OUT_LANES = 16,
    parameter int                IDX_W     = $clog2(IN_LEN),
    parameter int                STRIDE_W  = 4,
    parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IN_LEN*DATA_W-1:0]    in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IDX_W-1:0]            start_idx,
    input  logic [IDX_W-1:0]            end_idx,
    input  logic [STRIDE_W-1:0]         stride,
    output logic [OUT_LANES*DATA_W-1:0] out_data,
    output logic [OUT_LANES-1:0]        out_mask,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        cfg_err,
    output logic                        busy
);

    localparam int LANE_W = $clog2(OUT_LANES);
    localparam int CNT_W  = IDX_W + 1;             // element count 0..IN_LEN
    localparam int BEAT_W = IDX_W - LANE_W + 1;    // beat count 1..IN_LEN/OUT_LANES
    localparam int POS_W  = IDX_W + STRIDE_W + 1;  // wide enough that pos never wraps

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [DATA_W-1:0]             elem_q [IN_LEN];
    logic [IDX_W-1:0]              start_q, end_q;
    logic [STRIDE_W-1:0]           stride_q;
    logic                          zero_stride_q;
    logic [CNT_W-1:0]              n_q;
    logic [BEAT_W-1:0]             beats_q, b_q;
    logic                          cfg_err_q, in_ready_q, out_valid_q, out_last_q;
    logic [OUT_LANES-1:0]          out_mask_q;
    logic [OUT_LANES*DATA_W-1:0]   out_data_q;

    logic                          w_capture, w_load, w_done;
    logic [IDX_W-1:0]              w_diff;
    logic [POS_W-1:0]              w_n_full;
    logic [CNT_W-1:0]              w_n_calc, w_round;
    logic [BEAT_W-1:0]             w_beats_calc;
    logic [BEAT_W-1:0]             w_bsel, w_beats_sel;
    logic [CNT_W-1:0]              w_nsel;
    logic [POS_W-1:0]              w_k, w_pos;
    logic [OUT_LANES*DATA_W-1:0]   w_beat_data;
    logic [OUT_LANES-1:0]          w_beat_mask;
    logic                          w_beat_last;

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d   = state_q;
        w_capture = 1'b0;
        w_load    = 1'b0;
        w_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    w_capture = 1'b1;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                w_load  = 1'b1;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        w_done  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- element / beat count ----------------
    always_comb begin
        w_diff   = end_q - start_q;
        w_n_full = POS_W'(w_diff) / POS_W'(stride_q) + POS_W'(1);
        if (start_q > end_q) begin
            w_n_calc = '0;
        end else if (w_n_full > POS_W'(IN_LEN)) begin
            w_n_calc = CNT_W'(IN_LEN);
        end else begin
            w_n_calc = CNT_W'(w_n_full);
        end
        w_round      = w_n_calc + CNT_W'(OUT_LANES - 1);
        w_beats_calc = (w_n_calc == '0) ? BEAT_W'(1) : BEAT_W'(w_round >> LANE_W);
    end

    // In CALC the first beat is built from the freshly computed counts;
    // in EMIT the following beat is prepared from the registered ones.
    always_comb begin
        if (state_q == S_CALC) begin
            w_bsel      = '0;
            w_nsel      = w_n_calc;
            w_beats_sel = w_beats_calc;
        end else begin
            w_bsel      = b_q + BEAT_W'(1);
            w_nsel      = n_q;
            w_beats_sel = beats_q;
        end
        w_beat_last = (w_bsel == w_beats_sel - BEAT_W'(1));
    end

    // ---------------- beat builder ----------------
    always_comb begin
        w_beat_data = '0;
        w_beat_mask = '0;
        w_k         = '0;
        w_pos       = '0;
        for (int i = 0; i < OUT_LANES; i++) begin
            w_k   = POS_W'(w_bsel) * POS_W'(OUT_LANES) + POS_W'(i);
            w_pos = POS_W'(start_q) + w_k * POS_W'(stride_q);
            // The end bound is implied by k < N; keeping it also guards the
            // element index against any out-of-range position.
            if ((w_k < POS_W'(w_nsel)) && (w_pos <= POS_W'(end_q))) begin
                w_beat_data[i*DATA_W +: DATA_W] = elem_q[w_pos[IDX_W-1:0]];
                w_beat_mask[i]                  = 1'b1;
            end else begin
                w_beat_data[i*DATA_W +: DATA_W] = PAD_VALUE;
            end
        end
    end

    // ---------------- vector storage (no reset needed) ----------------
    always_ff @(posedge clk) begin
        if (w_capture && !rst) begin
            for (int j = 0; j < IN_LEN; j++) begin
                elem_q[j] <= in_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // ---------------- state and control registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            start_q       <= '0;
            end_q         <= '0;
            stride_q      <= STRIDE_W'(1);
            zero_stride_q <= 1'b0;
            n_q           <= '0;
            beats_q       <= '0;
            b_q           <= '0;
            cfg_err_q     <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_mask_q    <= '0;
            out_data_q    <= '0;
        end else begin
            state_q <= state_d;
            if (w_capture) begin
                start_q       <= start_idx;
                end_q         <= end_idx;
                // Stride 0 is executed as stride 1 and flagged.
                stride_q      <= (stride == '0) ? STRIDE_W'(1) : stride;
                zero_stride_q <= (stride == '0);
                in_ready_q    <= 1'b0;
            end
            if (state_q == S_CALC) begin
                n_q       <= w_n_calc;
                beats_q   <= w_beats_calc;
                b_q       <= '0;
                cfg_err_q <= zero_stride_q || (start_q > end_q);
            end else if (w_load) begin
                b_q <= w_bsel;
            end
            if (w_load) begin
                out_data_q  <= w_beat_data;
                out_mask_q  <= w_beat_mask;
                out_last_q  <= w_beat_last;
                out_valid_q <= 1'b1;
            end
            if (w_done) begin
                out_data_q  <= '0;
                out_mask_q  <= '0;
                out_last_q  <= 1'b0;
                out_valid_q <= 1'b0;
                cfg_err_q   <= 1'b0;
                in_ready_q  <= 1'b1;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_mask  = out_mask_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
